// File: rtl/glip_uart_host_link.sv
// Host-side end of the GLIP UART link: 8N1 serializer with 0xFE escape coding and
// credit-limited transmit, plus a deserializer that strips escapes and extracts credit grants.
module glip_uart_host_link #(
    parameter int DIVISOR      = 217,
    parameter int CREDIT_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    output logic                    uart_tx,
    input  logic                    uart_rx,
    input  logic                    uart_cts,
    output logic                    uart_rts,
    input  logic                    hold,
    output logic [CREDIT_WIDTH-1:0] credit,
    output logic                    error
);

    localparam logic [7:0] ESC_BYTE = 8'hFE;
    localparam int CNT_W = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
    localparam int SUM_W = ((CREDIT_WIDTH > 12) ? CREDIT_WIDTH : 12) + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'({CREDIT_WIDTH{1'b1}});

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_ESC2} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [1:0] {DEC_NORMAL, DEC_ESC, DEC_CRED_LO} dec_state_t;

    tx_state_t  tx_state, tx_state_next;
    rx_state_t  rx_state, rx_state_next;
    dec_state_t dec_state, dec_state_next;

    logic [7:0]       tx_shift, tx_shift_next;
    logic [2:0]       tx_bits, tx_bits_next;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_next;
    logic             tx_pend_esc, tx_pend_esc_next;
    logic             tx_line, tx_line_next;
    logic             tx_bit_end, accept;

    logic             rx_meta, rx_sync, cts_meta, cts_sync, rts_q;
    logic [7:0]       rx_shift, rx_shift_next;
    logic [2:0]       rx_bits, rx_bits_next;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_next;
    logic             rx_bit_end, rx_half_end, byte_done, frame_err;

    logic [3:0]             grant_hi, grant_hi_next;
    logic [11:0]            grant_add;
    logic                   emit, proto_err;
    logic [SUM_W-1:0]       credit_sum;
    logic [CREDIT_WIDTH-1:0] credit_next;

    assign in_ready    = (tx_state == TX_IDLE) && (credit != '0) && !cts_sync;
    assign tx_bit_end  = (tx_cnt == BIT_LAST);
    assign rx_bit_end  = (rx_cnt == BIT_LAST);
    assign rx_half_end = (rx_cnt == HALF_LAST);
    assign uart_tx     = tx_line;
    assign uart_rts    = rts_q;

    // The second escape frame starts straight out of STOP when CTS allows, so an escaped byte costs 20 bit times.
    always_comb begin
        tx_state_next    = tx_state;
        tx_shift_next    = tx_shift;
        tx_bits_next     = tx_bits;
        tx_cnt_next      = tx_cnt + CNT_W'(1);
        tx_pend_esc_next = tx_pend_esc;
        accept           = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_next = '0;
                if (in_valid && in_ready) begin
                    accept           = 1'b1;
                    tx_shift_next    = in_data;
                    tx_pend_esc_next = (in_data == ESC_BYTE);
                    tx_state_next    = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_cnt_next   = '0;
                    tx_bits_next  = '0;
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = {1'b0, tx_shift[7:1]};
                    tx_bits_next  = tx_bits + 3'd1;
                    if (tx_bits == 3'd7) tx_state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_next = '0;
                    if (!tx_pend_esc) begin
                        tx_state_next = TX_IDLE;
                    end else if (!cts_sync) begin
                        tx_state_next    = TX_START;
                        tx_shift_next    = ESC_BYTE;
                        tx_pend_esc_next = 1'b0;
                    end else begin
                        tx_state_next = TX_ESC2;
                    end
                end
            end
            TX_ESC2: begin
                tx_cnt_next = '0;
                if (!cts_sync) begin
                    tx_state_next    = TX_START;
                    tx_shift_next    = ESC_BYTE;
                    tx_pend_esc_next = 1'b0;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
        case (tx_state_next)
            TX_START: tx_line_next = 1'b0;
            TX_DATA:  tx_line_next = tx_shift_next[0];
            default:  tx_line_next = 1'b1;
        endcase
    end

    // Receive sampler plus escape/credit decoder; the decoder acts on the byte in the stop-bit sample cycle.
    always_comb begin
        rx_state_next  = rx_state;
        rx_shift_next  = rx_shift;
        rx_bits_next   = rx_bits;
        rx_cnt_next    = rx_cnt + CNT_W'(1);
        byte_done      = 1'b0;
        frame_err      = 1'b0;
        dec_state_next = dec_state;
        grant_hi_next  = grant_hi;
        grant_add      = '0;
        emit           = 1'b0;
        proto_err      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (!rx_sync) rx_state_next = RX_START;
            end
            RX_START: begin
                if (rx_half_end) begin
                    rx_cnt_next   = '0;
                    rx_bits_next  = '0;
                    rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    rx_bits_next  = rx_bits + 3'd1;
                    if (rx_bits == 3'd7) rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_next = '0;
                    if (rx_sync) begin
                        byte_done     = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        frame_err     = 1'b1;
                        rx_state_next = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_next = '0;
                if (rx_sync) rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
        if (byte_done) begin
            case (dec_state)
                DEC_NORMAL: begin
                    if (rx_shift == ESC_BYTE) dec_state_next = DEC_ESC;
                    else emit = 1'b1;
                end
                DEC_ESC: begin
                    dec_state_next = DEC_NORMAL;
                    if (rx_shift == ESC_BYTE) begin
                        emit = 1'b1;
                    end else if (rx_shift[7]) begin
                        grant_hi_next  = rx_shift[3:0];
                        dec_state_next = DEC_CRED_LO;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
                DEC_CRED_LO: begin
                    grant_add      = {grant_hi, rx_shift};
                    dec_state_next = DEC_NORMAL;
                end
                default: dec_state_next = DEC_NORMAL;
            endcase
        end
        // Acceptance only happens with credit>=1, so the subtraction cannot wrap.
        credit_sum  = SUM_W'(credit) + SUM_W'(grant_add) - SUM_W'(accept);
        credit_next = (credit_sum > CREDIT_MAX) ? CREDIT_WIDTH'(CREDIT_MAX) : credit_sum[CREDIT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= TX_IDLE;
            tx_shift    <= '0;
            tx_bits     <= '0;
            tx_cnt      <= '0;
            tx_pend_esc <= 1'b0;
            tx_line     <= 1'b1;
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            cts_meta    <= 1'b1;
            cts_sync    <= 1'b1;
            rts_q       <= 1'b0;
            rx_state    <= RX_IDLE;
            rx_shift    <= '0;
            rx_bits     <= '0;
            rx_cnt      <= '0;
            dec_state   <= DEC_NORMAL;
            grant_hi    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            credit      <= '0;
            error       <= 1'b0;
        end else begin
            tx_state    <= tx_state_next;
            tx_shift    <= tx_shift_next;
            tx_bits     <= tx_bits_next;
            tx_cnt      <= tx_cnt_next;
            tx_pend_esc <= tx_pend_esc_next;
            tx_line     <= tx_line_next;
            rx_meta     <= uart_rx;
            rx_sync     <= rx_meta;
            cts_meta    <= uart_cts;
            cts_sync    <= cts_meta;
            rts_q       <= hold;
            rx_state    <= rx_state_next;
            rx_shift    <= rx_shift_next;
            rx_bits     <= rx_bits_next;
            rx_cnt      <= rx_cnt_next;
            dec_state   <= dec_state_next;
            grant_hi    <= grant_hi_next;
            out_valid   <= emit;
            if (emit) out_data <= rx_shift;
            credit      <= credit_next;
            error       <= error | frame_err | proto_err;
        end
    end

endmodule

// File: tb/tb_glip_uart_host_link.sv
// Randomized scoreboard bench for glip_uart_host_link: drives 8N1 frames into uart_rx,
// decodes uart_tx frames, and checks both directions against queued expectations.
module tb_glip_uart_host_link;

    localparam int D       = 8;
    localparam int CW      = 12;
    localparam int H       = D / 2;
    localparam int RX_LAT  = H + 9 * D + 3;
    localparam int CMAX    = (1 << CW) - 1;
    localparam int TX_WAIT = 60 * D + 400;
    localparam logic [7:0] ESC = 8'hFE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          uart_tx;
    logic          uart_rx = 1'b1;
    logic          uart_cts = 1'b0;
    logic          uart_rts;
    logic          hold = 1'b0;
    logic [CW-1:0] credit;
    logic          error;

    typedef struct { logic [7:0] data; int startCyc; } rx_exp_t;
    typedef struct { logic [7:0] data; bit chkGap; } tx_exp_t;

    rx_exp_t rxExp[$];
    tx_exp_t txExp[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int modelCredit = 0;
    bit txMonIgnore = 1'b0;
    bit txGapCheck = 1'b1;

    glip_uart_host_link #(.DIVISOR(D), .CREDIT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .uart_cts(uart_cts), .uart_rts(uart_rts),
        .hold(hold), .credit(credit), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One raw 8N1 frame on uart_rx; consecutive calls leave zero idle time between frames.
    task automatic applyStimulus(input logic [7:0] b, input bit stopOk, input bit expectOut);
        if (expectOut) rxExp.push_back('{b, cyc});
        uart_rx = 1'b0;
        tick(D);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(D);
        end
        uart_rx = stopOk;
        tick(D);
    endtask

    task automatic rxPayload(input logic [7:0] b);
        if (b == ESC) begin
            applyStimulus(ESC, 1'b1, 1'b0);
            applyStimulus(ESC, 1'b1, 1'b1);
        end else begin
            applyStimulus(b, 1'b1, 1'b1);
        end
    endtask

    task automatic rxGrant(input int g);
        applyStimulus(ESC, 1'b1, 1'b0);
        applyStimulus(8'h80 | 8'(g >> 8), 1'b1, 1'b0);
        applyStimulus(8'(g & 255), 1'b1, 1'b0);
        modelCredit = (modelCredit + g > CMAX) ? CMAX : modelCredit + g;
    endtask

    task automatic txSend(input logic [7:0] b, input bit chkBusy);
        int waited;
        int acc;
        waited = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && waited < TX_WAIT) begin
            tick(1);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("txAcceptTimeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        tick(1);
        in_valid = 1'b0;
        acc = cyc;
        modelCredit--;
        if (!txMonIgnore) begin
            txExp.push_back('{b, 1'b0});
            if (b == ESC) txExp.push_back('{ESC, txGapCheck});
        end
        checkOutput("txStartDrop", uart_tx, 0);
        if (chkBusy) begin
            waited = 0;
            while (!in_ready && waited < 30 * D) begin
                tick(1);
                waited++;
            end
            checkOutput("txBusyCycles", cyc - acc, (b == ESC) ? 20 * D : 10 * D);
        end
    endtask

    // Transmit monitor: decodes each frame at bit centres and pops the expected byte.
    initial begin : txMonitor
        int startC;
        int lastStart;
        logic [7:0] data;
        logic startBit;
        logic stopBit;
        tx_exp_t e;
        lastStart = 0;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx == 1'b0) begin
                startC = cyc;
                repeat (H) @(negedge clk);
                startBit = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (D) @(negedge clk);
                    data[i] = uart_tx;
                end
                repeat (D) @(negedge clk);
                stopBit = uart_tx;
                if (!txMonIgnore) begin
                    if (txExp.size() == 0) begin
                        checkOutput("txUnexpectedFrame", txExp.size(), 1);
                    end else begin
                        e = txExp.pop_front();
                        checkOutput("txStartBit", startBit, 0);
                        checkOutput("txData", data, e.data);
                        checkOutput("txStopBit", stopBit, 1);
                        if (e.chkGap) checkOutput("txEscGap", startC - lastStart, 10 * D);
                    end
                end
                lastStart = startC;
            end
        end
    end

    // Receive monitor: every out_valid strobe must match the oldest expected byte and latency.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            rx_exp_t e;
            if (rxExp.size() == 0) begin
                checkOutput("rxUnexpectedByte", rxExp.size(), 1);
            end else begin
                e = rxExp.pop_front();
                checkOutput("rxData", out_data, e.data);
                checkOutput("rxLatency", cyc - e.startCyc, RX_LAT);
            end
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] b;
        tick(3);
        checkOutput("rstUartTx", uart_tx, 1);
        checkOutput("rstUartRts", uart_rts, 0);
        checkOutput("rstInReady", in_ready, 0);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstOutData", out_data, 0);
        checkOutput("rstCredit", credit, 0);
        checkOutput("rstError", error, 0);
        hold = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        checkOutput("rtsHigh", uart_rts, 1);
        hold = 1'b0;
        tick(2);
        checkOutput("rtsLow", uart_rts, 0);

        // Grant 3, then four bytes: the fourth stalls on zero credit.
        rxGrant(3);
        checkOutput("creditGrant3", credit, modelCredit);
        checkOutput("readyWithCredit", in_ready, 1);
        txSend(8'h41, 1'b1);
        txSend(8'h42, 1'b1);
        txSend(8'h43, 1'b0);
        in_data = 8'h44;
        in_valid = 1'b1;
        tick(12 * D);
        checkOutput("stallReady", in_ready, 0);
        checkOutput("stallCredit", credit, 0);
        checkOutput("stallTxIdle", uart_tx, 1);
        in_valid = 1'b0;

        // Escaped payload costs one credit and two frames.
        rxGrant(5);
        checkOutput("creditGrant5", credit, modelCredit);
        txSend(ESC, 1'b1);
        checkOutput("creditAfterEsc", credit, modelCredit);
        tick(2 * D);

        // Back-to-back receive with escape, then a start-bit glitch.
        rxPayload(8'h10);
        rxPayload(ESC);
        rxPayload(8'h7F);
        tick(2);
        checkOutput("rxNoError", error, 0);
        uart_rx = 1'b0;
        tick(2);
        uart_rx = 1'b1;
        tick(3 * D);
        checkOutput("glitchNoError", error, 0);

        // CTS raised mid-frame: frame completes, next start waits.
        txSend(8'h5A, 1'b0);
        tick(3 * D);
        uart_cts = 1'b1;
        tick(8 * D);
        checkOutput("ctsBlocksReady", in_ready, 0);
        in_data = 8'hA5;
        in_valid = 1'b1;
        tick(4 * D);
        checkOutput("ctsHoldsTx", uart_tx, 1);
        uart_cts = 1'b0;
        txSend(8'hA5, 1'b1);
        txGapCheck = 1'b0;
        txSend(ESC, 1'b0);
        tick(5 * D);
        uart_cts = 1'b1;
        tick(10 * D);
        checkOutput("ctsHoldsEsc2", uart_tx, 1);
        uart_cts = 1'b0;
        tick(14 * D);
        txGapCheck = 1'b1;
        checkOutput("creditAfterCts", credit, modelCredit);

        // Randomized concurrent traffic in both directions.
        fork
            begin
                rxGrant(20 + $urandom_range(0, 10));
                for (int i = 0; i < 20; i++) begin
                    if ($urandom_range(0, 4) == 0) rxGrant($urandom_range(1, 60));
                    else if ($urandom_range(0, 5) == 0) rxPayload(ESC);
                    else rxPayload(8'($urandom_range(0, 255)));
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    b = ($urandom_range(0, 3) == 0) ? ESC : 8'($urandom_range(0, 255));
                    txSend(b, 1'b0);
                end
            end
        join
        tick(22 * D);
        checkOutput("creditRandom", credit, modelCredit);

        // Protocol error is sticky and does not block later payload.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        modelCredit = 0;
        applyStimulus(ESC, 1'b1, 1'b0);
        applyStimulus(8'h05, 1'b1, 1'b0);
        checkOutput("protoError", error, 1);
        rxPayload(8'h22);
        checkOutput("protoErrorSticky", error, 1);

        // Framing error, then saturating grants.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        modelCredit = 0;
        applyStimulus(8'h33, 1'b0, 1'b0);
        uart_rx = 1'b1;
        tick(2 * D);
        checkOutput("framingError", error, 1);
        rxGrant(4093);
        checkOutput("credit4093", credit, modelCredit);
        rxGrant(5);
        checkOutput("creditSaturated", credit, modelCredit);

        // Reset in the middle of a transmit frame.
        rxPayload(8'h5C);
        hold = 1'b1;
        txMonIgnore = 1'b1;
        txSend(8'h77, 1'b0);
        tick(3 * D);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstUartTx", uart_tx, 1);
        checkOutput("midRstRts", uart_rts, 0);
        checkOutput("midRstReady", in_ready, 0);
        checkOutput("midRstOutValid", out_valid, 0);
        checkOutput("midRstOutData", out_data, 0);
        checkOutput("midRstCredit", credit, 0);
        checkOutput("midRstError", error, 0);
        hold = 1'b0;
        modelCredit = 0;
        tick(2);
        rst_n = 1'b1;
        tick(12 * D);
        checkOutput("postRstTxIdle", uart_tx, 1);
        txMonIgnore = 1'b0;

        checkOutput("rxQueueDrained", rxExp.size(), 0);
        checkOutput("txQueueDrained", txExp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
